// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder in front of a byte-wide RAM.
// Supports 0x02 (write) and 0x03 (read) with a 16-bit address; reads and
// writes stream through consecutive addresses and wrap at the top of memory.
// The SPI pins are oversampled on clk, so clk must run several times faster
// than spi_clk.
module spi_ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int CLK_DIV_MIN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic spi_clk,
  input  logic spi_select,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err
);

  // Below 6 clk per SCK period the two-cycle read pipeline can lose to the
  // next falling edge.
  if (ADDR_BITS < 2 || CLK_DIV_MIN < 6) begin : g_param_check
    $error("spi_ram_responder: needs ADDR_BITS >= 2 and CLK_DIV_MIN >= 6");
  end

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WRITE,
    READ,
    IGNORE
  } state_t;

  localparam int MEM_WORDS = 2 ** ADDR_BITS;

  logic [1:0]           sck_sync;
  logic [1:0]           sel_sync;
  logic [1:0]           mosi_sync;
  logic                 sck_d;
  logic                 sel_d;
  logic                 sck_s;
  logic                 sel_s;
  logic                 mosi_s;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 sel_rise;
  logic                 sel_fall;

  state_t               state;
  logic [3:0]           bit_cnt;
  logic [6:0]           shift_in;
  logic [ADDR_BITS-1:0] addr;
  logic                 is_read;
  logic [7:0]           tx_shift;
  logic [1:0]           load_pend;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;
  logic [7:0]           rd_data;
  logic [7:0]           mem [0:MEM_WORDS-1];

  assign sck_s    = sck_sync[1];
  assign sel_s    = sel_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign sel_rise = sel_s & ~sel_d;
  assign sel_fall = ~sel_s & sel_d;

  // Two-flop synchronisers plus one delay stage for edge detection; idle levels are select high, SCK low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync  <= 2'b00;
      sel_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      sel_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_clk};
      sel_sync  <= {sel_sync[0], spi_select};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_s;
      sel_d     <= sel_s;
    end
  end

  // Transaction FSM; rd_data lands two cycles after an address update and is then loaded into tx_shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift_in    <= 7'd0;
      addr        <= '0;
      is_read     <= 1'b0;
      tx_shift    <= 8'd0;
      load_pend   <= 2'b00;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= 8'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err   <= 1'b0;
      mem_we    <= 1'b0;
      load_pend <= {load_pend[0], 1'b0};
      if (load_pend[1]) begin
        tx_shift <= rd_data;
      end
      if (sel_rise) begin
        state       <= IDLE;
        bit_cnt     <= 4'd0;
        load_pend   <= 2'b00;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sel_fall) begin
              state   <= CMD;
              bit_cnt <= 4'd0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift_in <= {shift_in[5:0], mosi_s};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                case ({shift_in, mosi_s})
                  8'h03: begin
                    is_read <= 1'b1;
                    state   <= ADDR;
                  end
                  8'h02: begin
                    is_read <= 1'b0;
                    state   <= ADDR;
                  end
                  default: begin
                    state   <= IGNORE;
                    cmd_err <= 1'b1;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr <= {addr[ADDR_BITS-2:0], mosi_s};
              if (bit_cnt == 4'd15) begin
                bit_cnt <= 4'd0;
                if (is_read) begin
                  state       <= READ;
                  spi_miso_oe <= 1'b1;
                  load_pend   <= {load_pend[0], 1'b1};
                end else begin
                  state <= WRITE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          WRITE: begin
            if (sck_rise) begin
              shift_in <= {shift_in[5:0], mosi_s};
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                mem_we    <= 1'b1;
                mem_waddr <= addr;
                mem_wdata <= {shift_in, mosi_s};
                addr      <= addr + ADDR_BITS'(1);
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          READ: begin
            if (sck_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                addr      <= addr + ADDR_BITS'(1);
                load_pend <= {load_pend[0], 1'b1};
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            if (sck_fall) begin
              spi_miso <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          IGNORE: begin
            spi_miso_oe <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Byte RAM with registered read of the current address; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data <= mem[addr];
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: write/read, wrap, bad command,
// abort, reset mid-read and an 8x clock-ratio run with random phase.
module tb_spi_ram_responder;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_select = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic cmd_err;

  int checks_total = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int half_ns = 80;
  int phase_ns = 3;
  int err_pulses = 0;
  int err_before = 0;

  logic [7:0] r0, r1, dummy_rx;
  logic       hdr_any, data_all, dummy_any, dummy_all;
  logic       acc_any;
  logic [7:0] acc_rx;

  spi_ram_responder #(
    .ADDR_BITS(12),
    .CLK_DIV_MIN(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .spi_clk(spi_clk),
    .spi_select(spi_select),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Count clk cycles in which cmd_err is high, sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx MSB first in mode 0; MISO and OE are sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rxb, output logic any, output logic all);
    rxb = 8'd0;
    any = 1'b0;
    all = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      #(half_ns);
      rxb[i] = spi_miso;
      any = any | spi_miso_oe;
      all = all & spi_miso_oe;
      spi_clk = 1'b1;
      #(half_ns);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(posedge clk);
    #(phase_ns);
    spi_select = 1'b0;
  endtask

  task automatic spi_end();
    #(half_ns);
    spi_select = 1'b1;
    spi_mosi = 1'b0;
    #(4 * half_ns);
  endtask

  task automatic spi_write2(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] rxb;
    logic any, all;
    spi_begin();
    spi_bits(8'h02, 8, rxb, any, all);
    spi_bits(a[15:8], 8, rxb, any, all);
    spi_bits(a[7:0], 8, rxb, any, all);
    spi_bits(d0, 8, rxb, any, all);
    spi_bits(d1, 8, rxb, any, all);
    spi_end();
  endtask

  task automatic spi_read2(input logic [15:0] a, output logic [7:0] b0, output logic [7:0] b1,
                           output logic h_any, output logic d_all);
    logic any0, any1, any2, all0, all1;
    logic [7:0] rxb;
    spi_begin();
    spi_bits(8'h03, 8, rxb, any0, all0);
    spi_bits(a[15:8], 8, rxb, any1, all0);
    spi_bits(a[7:0], 8, rxb, any2, all0);
    h_any = any0 | any1 | any2;
    spi_bits(8'h00, 8, b0, any0, all0);
    spi_bits(8'h00, 8, b1, any0, all1);
    d_all = all0 & all1;
    spi_end();
  endtask

  initial begin
    $display("[TB] start");
    #33;
    rstn = 1'b1;
    #40;
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_oe", spi_miso_oe, 1'b0);
    check_output("reset_miso", spi_miso, 1'b0);
    check_output("reset_cmd_err", cmd_err, 1'b0);

    // Write then read at 0x0010
    spi_write2(16'h0010, 8'hA5, 8'h3C);
    check_output("write_busy_after", busy, 1'b0);
    spi_read2(16'h0010, r0, r1, hdr_any, data_all);
    check_output("read_b0", r0, 8'hA5);
    check_output("read_b1", r1, 8'h3C);
    check_output("read_hdr_oe", hdr_any, 1'b0);
    check_output("read_data_oe", data_all, 1'b1);
    check_output("read_oe_after", spi_miso_oe, 1'b0);

    // Address wrap: 0xFFFF maps to 0xFFF, next byte lands at 0x000
    spi_write2(16'hFFFF, 8'h11, 8'h22);
    spi_read2(16'h0FFF, r0, r1, hdr_any, data_all);
    check_output("wrap_b0", r0, 8'h11);
    check_output("wrap_b1", r1, 8'h22);
    spi_read2(16'h0000, r0, r1, hdr_any, data_all);
    check_output("wrap_addr0", r0, 8'h22);

    // Unsupported command
    check_output("no_err_yet", err_pulses, 0);
    err_before = err_pulses;
    spi_begin();
    spi_bits(8'h9F, 8, dummy_rx, acc_any, dummy_all);
    acc_rx = dummy_rx;
    spi_bits(8'h02, 8, dummy_rx, dummy_any, dummy_all);
    acc_any = acc_any | dummy_any;
    acc_rx = acc_rx | dummy_rx;
    spi_bits(8'h00, 8, dummy_rx, dummy_any, dummy_all);
    acc_any = acc_any | dummy_any;
    acc_rx = acc_rx | dummy_rx;
    spi_bits(8'h10, 8, dummy_rx, dummy_any, dummy_all);
    acc_any = acc_any | dummy_any;
    acc_rx = acc_rx | dummy_rx;
    spi_bits(8'hFF, 8, dummy_rx, dummy_any, dummy_all);
    acc_any = acc_any | dummy_any;
    acc_rx = acc_rx | dummy_rx;
    spi_end();
    check_output("badcmd_err_pulses", err_pulses - err_before, 1);
    check_output("badcmd_oe", acc_any, 1'b0);
    check_output("badcmd_miso", acc_rx, 8'h00);
    spi_read2(16'h0010, r0, r1, hdr_any, data_all);
    check_output("badcmd_keep_b0", r0, 8'hA5);
    check_output("badcmd_keep_b1", r1, 8'h3C);

    // Abort mid-byte: completed byte stays, partial byte discarded
    spi_write2(16'h0021, 8'h5A, 8'h77);
    spi_begin();
    spi_bits(8'h02, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'h00, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'h20, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'hAB, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'hCD, 4, dummy_rx, dummy_any, dummy_all);
    spi_end();
    check_output("abort_busy", busy, 1'b0);
    spi_read2(16'h0020, r0, r1, hdr_any, data_all);
    check_output("abort_b20", r0, 8'hAB);
    check_output("abort_b21", r1, 8'h5A);

    // Reset during the second data byte of a read
    spi_begin();
    spi_bits(8'h03, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'h00, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'h10, 8, dummy_rx, dummy_any, dummy_all);
    spi_bits(8'h00, 8, r0, dummy_any, dummy_all);
    check_output("rstmid_b0", r0, 8'hA5);
    spi_bits(8'h00, 4, dummy_rx, dummy_any, dummy_all);
    rstn = 1'b0;
    #1;
    check_output("rstmid_oe", spi_miso_oe, 1'b0);
    check_output("rstmid_busy", busy, 1'b0);
    check_output("rstmid_miso", spi_miso, 1'b0);
    spi_select = 1'b1;
    spi_clk = 1'b0;
    #30;
    rstn = 1'b1;
    #100;
    spi_read2(16'h0010, r0, r1, hdr_any, data_all);
    check_output("rstmid_retain_b0", r0, 8'hA5);
    check_output("rstmid_retain_b1", r1, 8'h3C);

    // clk = 8x spi_clk with random phase between the clocks
    half_ns = 40;
    for (int k = 0; k < 3; k++) begin
      phase_ns = $urandom_range(1, 9);
      spi_write2(16'h0010, 8'hA5, 8'h3C);
      phase_ns = $urandom_range(1, 9);
      spi_read2(16'h0010, r0, r1, hdr_any, data_all);
      check_output("fast_b0", r0, 8'hA5);
      check_output("fast_b1", r1, 8'h3C);
      check_output("fast_hdr_oe", hdr_any, 1'b0);
      check_output("fast_data_oe", data_all, 1'b1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, giving a memory of 2^ADDR_BITS bytes.
REQ-002 SHALL have parameter CLK_DIV_MIN, default 8, giving the minimum clk cycles per spi_clk period; it is documentation only and adds no logic.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port spi_clk, input, 1 bit: SPI clock from the initiator, asynchronous to clk.
REQ-006 SHALL have port spi_select, input, 1 bit: chip select, active-low, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1 bit: initiator-to-responder data.
REQ-008 SHALL have port spi_miso, output, 1 bit: responder-to-initiator data.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit: high while this block drives spi_miso.
REQ-010 SHALL have port busy, output, 1 bit: high while a transaction is active (synchronised select low).
REQ-011 SHALL have port cmd_err, output, 1 bit: single-clk pulse when an unsupported command byte completes.

Function
REQ-012 SHALL pass spi_clk, spi_select and spi_mosi through 2-flop synchronisers, then detect edges on the synchronised signals; correct operation is required when clk >= CLK_DIV_MIN x spi_clk.
REQ-013 SHALL use SPI mode 0, MSB first: sample MOSI on the detected SCK rising edge; update MISO on the detected SCK falling edge.
REQ-014 SHALL implement the state machine IDLE, CMD, ADDR, WRITE, READ, IGNORE.
REQ-015 IDLE -> CMD on the synchronised select falling edge; the bit counter clears to 0.
REQ-016 CMD: after 8 rising edges, command 0x03 -> ADDR(read), command 0x02 -> ADDR(write), any other value -> IGNORE with cmd_err pulsed for 1 clk.
REQ-017 ADDR: SHALL shift in 16 address bits MSB first; only addr[ADDR_BITS-1:0] is used and the upper bits are ignored.
REQ-018 WRITE: after each 8 further rising edges, SHALL write the byte to mem[addr], then addr <= addr+1 modulo 2^ADDR_BITS (wrap to 0).
REQ-019 READ: on the 24th rising edge, SHALL issue a memory read of mem[addr], load the shift register before the next detected falling edge, and assert spi_miso_oe.
REQ-020 READ: each falling edge SHALL present the next bit; the byte MSB is presented on the first falling edge after bit 24.
REQ-021 READ: after 8 bits, SHALL prefetch mem[addr+1] (wrapping) so that streaming continues with no gap.
REQ-022 IGNORE SHALL hold spi_miso_oe=0 and write nothing until deselect.
REQ-023 Synchronised select rising edge, from any state, SHALL go -> IDLE, clear spi_miso_oe, and discard any partial write byte; bytes already completed stay written.
REQ-024 If a select rise and an SCK edge are detected in the same clk, select SHALL take priority and the SCK edge is ignored.
REQ-025 When not driving, spi_miso SHALL be 0 and spi_miso_oe SHALL be 0.
REQ-026 busy SHALL be high from the select fall detection to the select rise detection inclusive of that state span.

Reset
REQ-027 rstn low SHALL immediately force state=IDLE, spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0, bit counter=0, addr=0, and clear the synchroniser flops to idle levels (select=1, clk=0).
REQ-028 Memory contents SHALL NOT be reset; they are preserved across rstn assertion, including reset mid-write, where only the in-flight partial byte is lost.

Verification
REQ-029 Write then read: write 0x02, 0x0010, data A5 3C, deselect; read 0x03, 0x0010, 16 clocks -> MISO returns A5 then 3C, with spi_miso_oe high only during the data phase.
REQ-030 Wrap: write at 0xFFFF (ADDR_BITS=12 -> 0xFFF) data 11 22 -> mem[0xFFF]=11, mem[0x000]=22; a read at 0x0FFF streams 11 22.
REQ-031 Bad command: 0x9F -> cmd_err pulses for exactly 1 clk, spi_miso_oe stays 0, and a subsequent read of an unwritten-by-test address returns its prior content unchanged.
REQ-032 Abort: write 0x02 0x0020 then 0xAB followed by 4 bits of 0xCD, deselect -> mem[0x20]=AB, mem[0x21] unchanged, state back in IDLE, busy=0.
REQ-033 Reset mid-read: assert rstn low during the 2nd data byte -> spi_miso_oe=0 within the same cycle; after release, a new read of 0x0010 returns A5, confirming memory is retained.
REQ-034 Rate margin: run REQ-029 at clk = 8x spi_clk with random phase between the clocks -> data identical to the nominal run.
